// File: rtl/overlap_pkg.sv
// Shared width parameters and FSM state type for the overlap scanner.
package overlap_pkg;

    localparam int W     = 65;
    localparam int IDX_W = $clog2(W);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/overlap_lsb_enc.sv
// Combinational lowest-set-bit encoder; also flags an empty or single-bit vector.
module overlap_lsb_enc #(
    parameter int W     = overlap_pkg::W,
    parameter int IDX_W = overlap_pkg::IDX_W
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic             single
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] vec_minus_one;

    // Scanning downwards lets the lowest set bit win the final assignment.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign vec_minus_one = vec - ONE;
    assign found         = |vec;
    assign single        = found && ((vec & vec_minus_one) == '0);

endmodule

// File: rtl/overlap_scan.sv
// Captures a&b and emits one beat per matching pair index, lowest first.
// Define OVERLAP_SCAN_COUNT_EN to add the out_count popcount output.
module overlap_scan
    import overlap_pkg::*;
#(
    parameter int W     = overlap_pkg::W,
    parameter int IDX_W = overlap_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
`ifdef OVERLAP_SCAN_COUNT_EN
    output logic [IDX_W:0]   out_count,
`endif
    output logic             out_any
);

    localparam logic [W-1:0] ONE = W'(1);

    state_t           state_q;
    logic [W-1:0]     mask_q;
    logic [W-1:0]     mask_d;
    logic             out_any_q;
    logic [W-1:0]     pair_and;
    logic [IDX_W-1:0] lsb_idx;
    logic             lsb_found;
    logic             lsb_single;

    assign pair_and = in_a & in_b;

    overlap_lsb_enc #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_lsb_enc (
        .vec    (mask_q),
        .idx    (lsb_idx),
        .found  (lsb_found),
        .single (lsb_single)
    );

    // Dropping the lowest set bit is exactly clearing the bit at out_idx.
    assign mask_d = mask_q & (mask_q - ONE);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign out_idx   = lsb_idx;
    assign out_none  = (state_q == SCAN) && !lsb_found;
    assign out_last  = (state_q == SCAN) && (!lsb_found || lsb_single);
    assign out_any   = out_any_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            out_any_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mask_q    <= pair_and;
                        out_any_q <= |pair_and;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        mask_q <= mask_d;
                        if (out_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef OVERLAP_SCAN_COUNT_EN
    logic [IDX_W:0] count_d;
    logic [IDX_W:0] count_q;

    always_comb begin
        count_d = '0;
        for (int i = 0; i < W; i++) begin
            count_d = count_d + (IDX_W + 1)'(pair_and[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (in_valid && in_ready) begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_overlap_scan.sv
// Directed bench for overlap_scan: reset, beat ordering, stalls, mid-scan reset, random masks.
module tb_overlap_scan;

    localparam int W     = 65;
    localparam int IDX_W = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_none;
    logic             out_any;
`ifdef OVERLAP_SCAN_COUNT_EN
    logic [IDX_W:0]   out_count;
`endif

    int checks   = 0;
    int failures = 0;

    int got_idx[$];
    bit got_last[$];
    bit got_none[$];
    int stab_err;
    int ir_err;
    bit col_done;

    overlap_scan #(.W(W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
`ifdef OVERLAP_SCAN_COUNT_EN
        .out_count (out_count),
`endif
        .out_any   (out_any)
    );

    always #5 clk = ~clk;

    // Offer one pair once in_ready is seen; afterwards the inputs carry junk.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_valid);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: in_ready=%0b expected 1", in_ready);
        end
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
        in_a = ~a;
        in_b = ~b;
        $display("pair a=%h b=%h accepted", a, b);
    endtask

    // Drain beats until out_last is handshaken, recording them and any stall instability.
    task automatic collect(input bit stall, input int budget);
        logic [IDX_W-1:0] p_idx;
        logic             p_last;
        logic             p_none;
        bit               stalled;
        got_idx.delete();
        got_last.delete();
        got_none.delete();
        stab_err = 0;
        ir_err   = 0;
        col_done = 1'b0;
        stalled  = 1'b0;
        p_idx    = '0;
        p_last   = 1'b0;
        p_none   = 1'b0;
        for (int cyc = 0; cyc < budget && !col_done; cyc++) begin
            out_ready = stall ? cyc[0] : 1'b1;
            if (out_valid) begin
                if (in_ready) ir_err++;
                if (stalled && (out_idx !== p_idx || out_last !== p_last || out_none !== p_none))
                    stab_err++;
                if (out_ready) begin
                    got_idx.push_back(int'(out_idx));
                    got_last.push_back(out_last);
                    got_none.push_back(out_none);
                    if (out_last) col_done = 1'b1;
                end
                stalled = !out_ready;
                p_idx   = out_idx;
                p_last  = out_last;
                p_none  = out_none;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_any !== 1'b0 || out_idx !== '0 || out_last !== 1'b0 || out_none !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b any=%0b idx=%0d last=%0b none=%0b expected all 0",
                     out_valid, out_any, out_idx, out_last, out_none);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
        end
`ifdef OVERLAP_SCAN_COUNT_EN
        checks++;
        if (out_count !== '0) begin
            failures++;
            $display("FAIL reset_count: got %0d expected 0", out_count);
        end
`endif
    endtask

    task automatic test_two_bits();
        logic [W-1:0] a, b;
        a = '0; a[3] = 1'b1; a[64] = 1'b1;
        b = a;  b[10] = 1'b1;
        send(a, b, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_any !== 1'b1) begin
            failures++;
            $display("FAIL two_bits_latency: valid=%0b any=%0b expected 1/1", out_valid, out_any);
        end
`ifdef OVERLAP_SCAN_COUNT_EN
        checks++;
        if (out_count !== 8'd2) begin
            failures++;
            $display("FAIL two_bits_count: got %0d expected 2", out_count);
        end
`endif
        collect(1'b0, 20);
        checks++;
        if (!col_done || got_idx.size() != 2) begin
            failures++;
            $display("FAIL two_bits_beats: got %0d beats (done=%0b) expected 2", got_idx.size(), col_done);
        end else begin
            checks++;
            if (got_idx[0] != 3 || got_last[0] != 1'b0 || got_idx[1] != 64 || got_last[1] != 1'b1) begin
                failures++;
                $display("FAIL two_bits_order: got idx %0d/%0d last %0b/%0b expected 3/64 last 0/1",
                         got_idx[0], got_idx[1], got_last[0], got_last[1]);
            end
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_any !== 1'b1) begin
            failures++;
            $display("FAIL two_bits_idle: in_ready=%0b valid=%0b any=%0b expected 1/0/1",
                     in_ready, out_valid, out_any);
        end
    endtask

    task automatic test_none();
        logic [W-1:0] a, b;
        a = '1;
        b = '0;
        send(a, b, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_none !== 1'b1 || out_last !== 1'b1 || out_idx !== '0 || out_any !== 1'b0) begin
            failures++;
            $display("FAIL none_beat: valid=%0b none=%0b last=%0b idx=%0d any=%0b expected 1/1/1/0/0",
                     out_valid, out_none, out_last, out_idx, out_any);
        end
`ifdef OVERLAP_SCAN_COUNT_EN
        checks++;
        if (out_count !== '0) begin
            failures++;
            $display("FAIL none_count: got %0d expected 0", out_count);
        end
`endif
        collect(1'b0, 20);
        checks++;
        if (!col_done || got_idx.size() != 1 || got_none[0] != 1'b1) begin
            failures++;
            $display("FAIL none_single: got %0d beats (done=%0b) expected 1 beat with none=1", got_idx.size(), col_done);
        end
    endtask

    task automatic test_stall_all();
        logic [W-1:0] a;
        bit bad;
        a = '1;
        send(a, a, 1'b0);
`ifdef OVERLAP_SCAN_COUNT_EN
        checks++;
        if (out_count !== 8'd65) begin
            failures++;
            $display("FAIL stall_count: got %0d expected 65", out_count);
        end
`endif
        collect(1'b1, 400);
        checks++;
        if (!col_done || got_idx.size() != W) begin
            failures++;
            $display("FAIL stall_beats: got %0d beats (done=%0b) expected 65", got_idx.size(), col_done);
        end else begin
            bad = 1'b0;
            for (int i = 0; i < W; i++)
                if (got_idx[i] != i || got_last[i] != (i == W - 1)) bad = 1'b1;
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL stall_order: indices or last flags not 0..64 ascending (first=%0d final=%0d)",
                         got_idx[0], got_idx[W-1]);
            end
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL stall_stable: got %0d changes while stalled expected 0", stab_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a, c;
        a = '0; a[1] = 1'b1; a[5] = 1'b1; a[20] = 1'b1; a[40] = 1'b1; a[64] = 1'b1;
        send(a, a, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 7'd20) begin
            failures++;
            $display("FAIL midrst_third: valid=%0b idx=%0d expected 1/20", out_valid, out_idx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: out_valid=%0b expected 0", out_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_any !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release: in_ready=%0b valid=%0b any=%0b expected 1/0/0",
                     in_ready, out_valid, out_any);
        end
        out_ready = 1'b0;
        c = '0; c[7] = 1'b1;
        send(c, c, 1'b0);
        collect(1'b0, 20);
        checks++;
        if (!col_done || got_idx.size() != 1 || got_idx[0] != 7 || got_last[0] != 1'b1) begin
            failures++;
            $display("FAIL midrst_clean: got %0d beats first idx %0d expected 1 beat idx 7",
                     got_idx.size(), (got_idx.size() > 0) ? got_idx[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] p1, p2;
        p1 = '0; p1[2] = 1'b1; p1[9] = 1'b1;
        p2 = '0; p2[30] = 1'b1;
        send(p1, p1, 1'b1);
        in_a = p2;
        in_b = p2;
        collect(1'b0, 20);
        checks++;
        if (!col_done || got_idx.size() != 2 || got_idx[0] != 2 || got_idx[1] != 9) begin
            failures++;
            $display("FAIL b2b_first: got %0d beats expected 2 (idx 2,9)", got_idx.size());
        end
        checks++;
        if (ir_err != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: busy-ready cycles %0d in_ready=%0b expected 0/1", ir_err, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(1'b0, 20);
        checks++;
        if (!col_done || got_idx.size() != 1 || got_idx[0] != 30) begin
            failures++;
            $display("FAIL b2b_second: got %0d beats first idx %0d expected 1 beat idx 30",
                     got_idx.size(), (got_idx.size() > 0) ? got_idx[0] : -1);
        end
    endtask

    task automatic test_random();
        logic [95:0]  ra, rb;
        logic [W-1:0] a, b, m;
        int exp_idx[$];
        bit bad;
        for (int it = 0; it < 4; it++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            a  = ra[W-1:0];
            b  = rb[W-1:0];
            m  = a & b;
            exp_idx.delete();
            for (int i = 0; i < W; i++)
                if (m[i]) exp_idx.push_back(i);
            send(a, b, 1'b0);
            checks++;
            if (out_any !== (|m)) begin
                failures++;
                $display("FAIL rand_any[%0d]: got %0b expected %0b", it, out_any, |m);
            end
            collect(1'b0, 100);
            bad = !col_done;
            if (exp_idx.size() == 0) begin
                if (got_idx.size() != 1 || got_none[0] != 1'b1) bad = 1'b1;
            end else if (got_idx.size() != exp_idx.size()) begin
                bad = 1'b1;
            end else begin
                for (int i = 0; i < exp_idx.size(); i++)
                    if (got_idx[i] != exp_idx[i]) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL rand_beats[%0d]: got %0d beats expected %0d", it, got_idx.size(), exp_idx.size());
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        test_reset();
        test_two_bits();
        test_none();
        test_stall_all();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/overlap_scan.md
OVERLAP_SCAN -- requirements
Module: overlap_scan

Interface
REQ-001 SHALL have parameter W, default 65, pair-vector width (one bit per A/B pair).
REQ-002 SHALL have parameter IDX_W, default 7, index width, equal to $clog2(W).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  vector pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a vector pair.
REQ-007 SHALL have port in_a  input  W  first operand vector.
REQ-008 SHALL have port in_b  input  W  second operand vector.
REQ-009 SHALL have port out_valid  output  1  result beat present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-011 SHALL have port out_idx  output  IDX_W  index of the current matching pair (a[i]&b[i]).
REQ-012 SHALL have port out_last  output  1  final beat of the current vector pair.
REQ-013 SHALL have port out_none  output  1  no pair matched; the single beat for this vector pair.
REQ-014 SHALL have port out_any  output  1  registered OR-reduction of in_a&in_b for the last accepted pair.

Function
REQ-015 SHALL implement the states IDLE and SCAN only.
REQ-016 SHALL drive in_ready=1 in IDLE and in_ready=0 in SCAN; there is no overlap between input pairs.
REQ-017 SHALL capture mask=in_a&in_b and set out_any=|mask on the in_valid&in_ready edge, then enter SCAN.
REQ-018 SHALL assert out_valid in the cycle after the accept edge (latency 1) and hold it high throughout SCAN.
REQ-019 SHALL drive out_idx to the lowest set bit index of the remaining mask.
REQ-020 SHALL assert out_last when exactly one bit remains.
REQ-021 SHALL clear the bit at out_idx on each out_valid&out_ready edge.
REQ-022 SHALL hold out_idx, out_last and out_none stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, when mask==0, emit exactly one beat with out_none=1, out_last=1, out_idx=0.
REQ-024 SHALL return to IDLE on the handshake of the last beat; in_ready rises in the next cycle.
REQ-025 SHALL enumerate bit W-1 (index 64) correctly; a mask of all-ones yields W beats, indices 0..W-1 ascending.
REQ-026 SHALL hold out_any until the next input accept.
REQ-027 SHALL ignore in_a and in_b outside the accept edge.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, mask=0, out_valid=0, out_any=0, out_idx=0, out_last=0, out_none=0, and in_ready=1 after release.
REQ-029 SHALL, on reset mid-SCAN, abort the scan, drop out_valid asynchronously, and emit no further beats for that pair.

Configuration
REQ-030 SHALL, with OVERLAP_SCAN_COUNT_EN defined, add output out_count, IDX_W+1 bits, equal to the popcount of the captured mask, valid and stable from the cycle after accept until the next accept, and reset to 0.
REQ-031 SHALL, without OVERLAP_SCAN_COUNT_EN, omit the out_count port and all popcount logic; all other behaviour is identical.

Structure
REQ-032 SHALL place W, IDX_W and the state enum (IDLE, SCAN) in the shared package overlap_pkg.
REQ-033 SHALL implement the lowest-set-bit search in one combinational sub-module, overlap_lsb_enc (inputs: vec[W]; outputs: idx[IDX_W], found, single).

Verification
REQ-034 SHALL test a=bit3|bit64, b=bit3|bit64|bit10, out_ready=1 -> beats idx 3 then 64 (last=1), out_any=1, out_count=2.
REQ-035 SHALL test a=all-ones, b=0 -> one beat with out_none=1, out_last=1, out_any=0, out_count=0.
REQ-036 SHALL test a=b=all-ones with out_ready toggled every other cycle -> 65 beats, idx 0..64 in order, each held stable while stalled.
REQ-037 SHALL test rst_n low after the 2nd of 5 beats -> out_valid=0 immediately, in_ready=1 after release, next pair starts clean.
REQ-038 SHALL test in_valid held high through a scan with new in_a/in_b values -> the new pair is accepted only in IDLE after the last handshake.
REQ-039 SHALL run a random-vector check -> out_any equals |(a&b), and the beat set equals the set bits of a&b.
